// File: rtl/io_stream_responder.sv
// io_stream_responder: CPU I/O port responder bridging to TX/RX byte FIFOs and a tick counter.
module io_stream_responder #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned FIFO_AW   = 3,
    parameter logic [15:0] TX_ADDR   = 16'h1000,
    parameter logic [15:0] STAT_ADDR = 16'h2000,
    parameter logic [15:0] TICK_ADDR = 16'h4000
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic [15:0]      io_addr,
    input  logic             io_write_enable,
    input  logic             io_read_enable,
    input  logic [WIDTH-1:0] io_wdata,
    output logic [WIDTH-1:0] io_data_in,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready
);

    localparam int unsigned DEPTH    = 1 << FIFO_AW;
    localparam int unsigned CW       = FIFO_AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [7:0]         tx_mem [DEPTH];
    logic [7:0]         rx_mem [DEPTH];
    logic [FIFO_AW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
    logic [CW-1:0]      tx_count, rx_count;
    logic [CW-1:0]      tx_count_nxt, rx_count_nxt;
    logic               tx_ovf, rx_ovf, tx_ovf_nxt, rx_ovf_nxt;
    logic [WIDTH-1:0]   tick, tick_nxt;

    logic sel_tx, sel_stat, sel_tick;
    logic tx_wr, rx_rd, stat_wr, tick_wr;
    logic tx_full, tx_empty, rx_full, rx_nonempty;
    logic tx_pop, tx_push, tx_drop;
    logic rx_pop, rx_push, rx_drop;
    logic [5:0] status;

    // Address decode, FIFO handshakes and next-state values.
    always_comb begin
        sel_tx      = (io_addr == TX_ADDR);
        sel_stat    = (io_addr == STAT_ADDR);
        sel_tick    = (io_addr == TICK_ADDR);
        tx_wr       = io_write_enable & sel_tx;
        stat_wr     = io_write_enable & sel_stat;
        tick_wr     = io_write_enable & sel_tick;
        // a simultaneous write wins and suppresses the RX pop
        rx_rd       = io_read_enable & ~io_write_enable & sel_tx;

        tx_full     = (tx_count == FULL_CNT);
        tx_empty    = (tx_count == '0);
        rx_full     = (rx_count == FULL_CNT);
        rx_nonempty = (rx_count != '0);

        tx_pop      = tx_valid & tx_ready;
        tx_push     = tx_wr & (~tx_full | tx_pop);
        tx_drop     = tx_wr & ~tx_push;

        rx_pop      = rx_rd & rx_nonempty;
        // a byte arriving while full is taken when the CPU frees a slot in the same cycle
        rx_push     = rx_valid & (rx_ready | rx_pop);
        rx_drop     = rx_valid & ~rx_push;

        tx_count_nxt = tx_count + CW'(tx_push) - CW'(tx_pop);
        rx_count_nxt = rx_count + CW'(rx_push) - CW'(rx_pop);

        // new overflow beats a same-cycle clear
        tx_ovf_nxt = (tx_ovf & ~(stat_wr & io_wdata[4])) | tx_drop;
        rx_ovf_nxt = (rx_ovf & ~(stat_wr & io_wdata[5])) | rx_drop;

        tick_nxt = tick_wr ? (io_wdata + WIDTH'(1)) : (tick + WIDTH'(1));

        status = {rx_ovf, tx_ovf, rx_full, rx_nonempty, tx_empty, tx_full};
    end

    // Zero-latency read mux; the core samples this in the strobe cycle.
    always_comb begin
        io_data_in = '0;
        if (sel_tx) begin
            if (rx_nonempty) io_data_in = WIDTH'(rx_mem[rx_rd_ptr]);
        end else if (sel_stat) begin
            io_data_in = WIDTH'(status);
        end else if (sel_tick) begin
            io_data_in = tick;
        end
    end

    assign tx_data = tx_valid ? tx_mem[tx_rd_ptr] : 8'h00;

    // Control state: pointers, counts, handshake flags, sticky flags and tick.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            tx_count  <= '0;
            rx_count  <= '0;
            tx_valid  <= 1'b0;
            rx_ready  <= 1'b1;
            tx_ovf    <= 1'b0;
            rx_ovf    <= 1'b0;
            tick      <= '0;
        end else begin
            tx_wr_ptr <= tx_wr_ptr + FIFO_AW'(tx_push);
            tx_rd_ptr <= tx_rd_ptr + FIFO_AW'(tx_pop);
            rx_wr_ptr <= rx_wr_ptr + FIFO_AW'(rx_push);
            rx_rd_ptr <= rx_rd_ptr + FIFO_AW'(rx_pop);
            tx_count  <= tx_count_nxt;
            rx_count  <= rx_count_nxt;
            tx_valid  <= (tx_count_nxt != '0);
            rx_ready  <= (rx_count_nxt != FULL_CNT);
            tx_ovf    <= tx_ovf_nxt;
            rx_ovf    <= rx_ovf_nxt;
            tick      <= tick_nxt;
        end
    end

    // FIFO storage; contents are don't-care outside the valid window, so no reset.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= io_wdata[7:0];
        if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
    end

endmodule

// File: tb/tb_io_stream_responder.sv
// Scoreboard bench for io_stream_responder: queues of expected TX/RX bytes plus flag/tick model.
module tb_io_stream_responder;

    localparam logic [15:0] TX_A = 16'h1000;
    localparam logic [15:0] ST_A = 16'h2000;
    localparam logic [15:0] TK_A = 16'h4000;

    logic        clk = 1'b0;
    logic        resetq = 1'b0;
    logic [15:0] io_addr;
    logic        io_write_enable, io_read_enable;
    logic [31:0] io_wdata, io_data_in;
    logic [7:0]  tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_ready;

    always #5 clk = ~clk;

    io_stream_responder #(.WIDTH(32), .FIFO_AW(3)) dut (
        .clk(clk), .resetq(resetq), .io_addr(io_addr),
        .io_write_enable(io_write_enable), .io_read_enable(io_read_enable),
        .io_wdata(io_wdata), .io_data_in(io_data_in),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic        tx_ovf_m, rx_ovf_m;
    logic [31:0] tick_m;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] stat_m();
        return {26'd0, rx_ovf_m, tx_ovf_m, rx_q.size() == 8, rx_q.size() != 0,
                tx_q.size() == 0, tx_q.size() == 8};
    endfunction

    function automatic logic [31:0] exp_read(input logic [15:0] a);
        if (a == TX_A) return (rx_q.size() != 0) ? 32'(rx_q[0]) : 32'd0;
        if (a == ST_A) return stat_m();
        if (a == TK_A) return tick_m;
        return 32'd0;
    endfunction

    task automatic set_idle();
        io_addr = 16'h0; io_write_enable = 1'b0; io_read_enable = 1'b0;
        io_wdata = 32'h0; rx_valid = 1'b0; rx_data = 8'h0;
    endtask

    task automatic model_reset();
        tx_q.delete(); rx_q.delete();
        tx_ovf_m = 1'b0; rx_ovf_m = 1'b0; tick_m = 32'h0;
    endtask

    // One clock: compare strobe-cycle outputs, advance the model, check flags after the edge.
    task automatic cycle();
        logic wr_tx, rd_tx, tx_pop, rx_pop, tx_push, rx_push, drop_tx, drop_rx;
        logic clr_tx, clr_rx, ld_tick;
        logic [31:0] wd;
        logic [7:0]  rd_byte;
        #1;
        wr_tx   = io_write_enable && io_addr == TX_A;
        rd_tx   = io_read_enable && !io_write_enable && io_addr == TX_A;
        tx_pop  = tx_ready && tx_q.size() != 0;
        if (tx_pop) check_val("tx_pop_data", 32'(tx_data), 32'(tx_q[0]));
        if (rd_tx)  check_val("rx_read_data", io_data_in, exp_read(TX_A));
        rx_pop  = rd_tx && rx_q.size() != 0;
        tx_push = wr_tx && (tx_q.size() < 8 || tx_pop);
        drop_tx = wr_tx && !tx_push;
        rx_push = rx_valid && (rx_q.size() < 8 || rx_pop);
        drop_rx = rx_valid && !rx_push;
        clr_tx  = io_write_enable && io_addr == ST_A && io_wdata[4];
        clr_rx  = io_write_enable && io_addr == ST_A && io_wdata[5];
        ld_tick = io_write_enable && io_addr == TK_A;
        wd      = io_wdata;
        rd_byte = rx_data;
        @(posedge clk);
        if (tx_pop)  void'(tx_q.pop_front());
        if (tx_push) tx_q.push_back(wd[7:0]);
        if (rx_pop)  void'(rx_q.pop_front());
        if (rx_push) rx_q.push_back(rd_byte);
        tx_ovf_m = (tx_ovf_m && !clr_tx) || drop_tx;
        rx_ovf_m = (rx_ovf_m && !clr_rx) || drop_rx;
        tick_m   = ld_tick ? wd + 32'd1 : tick_m + 32'd1;
        #1;
        set_idle();
        check_val("tx_valid", 32'(tx_valid), 32'(tx_q.size() != 0));
        check_val("rx_ready", 32'(rx_ready), 32'(rx_q.size() != 8));
        if (tx_q.size() != 0) check_val("tx_head", 32'(tx_data), 32'(tx_q[0]));
    endtask

    task automatic peek(input string tag, input logic [15:0] a);
        io_addr = a;
        #1;
        check_val(tag, io_data_in, exp_read(a));
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [31:0] d);
        io_addr = a; io_write_enable = 1'b1; io_wdata = d;
        cycle();
    endtask

    task automatic cpu_pop();
        io_addr = TX_A; io_read_enable = 1'b1;
        cycle();
    endtask

    task automatic rx_send(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        set_idle();
        tx_ready = 1'b0;
        model_reset();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_tx_valid", 32'(tx_valid), 32'd0);
        check_val("rst_tx_data", 32'(tx_data), 32'd0);
        check_val("rst_rx_ready", 32'(rx_ready), 32'd1);
        peek("rst_stat", ST_A);
        check_val("rst_stat_const", io_data_in, 32'h2);
        peek("rst_tick", TK_A);
        set_idle();
        resetq = 1'b1;

        // 1: single TX byte, then drain
        cpu_wr(TX_A, 32'h1A5);
        check_val("t1_valid", 32'(tx_valid), 32'd1);
        check_val("t1_data", 32'(tx_data), 32'hA5);
        tx_ready = 1'b1;
        cycle();
        tx_ready = 1'b0;
        check_val("t1_valid_after", 32'(tx_valid), 32'd0);
        peek("t1_stat", ST_A);
        check_val("t1_empty_bit", 32'(io_data_in[1]), 32'd1);
        set_idle();

        // 2: overflow TX, drain 1..8, clear tx_ovf
        for (int i = 1; i <= 9; i++) cpu_wr(TX_A, 32'(i));
        peek("t2_stat", ST_A);
        check_val("t2_full_ovf", io_data_in & 32'h11, 32'h11);
        set_idle();
        tx_ready = 1'b1;
        repeat (8) cycle();
        tx_ready = 1'b0;
        check_val("t2_drained", 32'(tx_valid), 32'd0);
        cpu_wr(ST_A, 32'h10);
        peek("t2_stat_clr", ST_A);
        check_val("t2_ovf_clear", 32'(io_data_in[4]), 32'd0);
        set_idle();

        // 3: RX push and CPU pops
        rx_send(8'h11);
        rx_send(8'h22);
        peek("t3_stat", ST_A);
        peek("t3_head", TX_A);
        check_val("t3_head_const", io_data_in, 32'h11);
        set_idle();
        cpu_pop();
        peek("t3_head2", TX_A);
        check_val("t3_head2_const", io_data_in, 32'h22);
        set_idle();
        cpu_pop();
        peek("t3_empty_read", TX_A);
        peek("t3_stat_empty", ST_A);
        set_idle();
        cpu_pop();                      // pop on empty is a no-op

        // both strobes: write wins, no RX pop
        rx_send(8'h33);
        io_addr = TX_A; io_write_enable = 1'b1; io_read_enable = 1'b1; io_wdata = 32'h5C;
        cycle();
        peek("both_rx_kept", TX_A);
        set_idle();
        tx_ready = 1'b1;
        cycle();
        tx_ready = 1'b0;
        cpu_pop();

        // 4: fill RX, overflow, pop+push while full, clear vs new overflow
        for (int i = 0; i < 8; i++) rx_send(8'(8'h40 + i));
        check_val("t4_rx_ready", 32'(rx_ready), 32'd0);
        peek("t4_stat_full", ST_A);
        set_idle();
        rx_send(8'h99);
        peek("t4_stat_ovf", ST_A);
        set_idle();
        io_addr = TX_A; io_read_enable = 1'b1; rx_valid = 1'b1; rx_data = 8'hAB;
        cycle();
        peek("t4_stat_popush", ST_A);
        set_idle();
        rx_valid = 1'b1; rx_data = 8'hCD; io_addr = ST_A; io_write_enable = 1'b1; io_wdata = 32'h20;
        cycle();
        peek("t4_stat_clr_race", ST_A);
        check_val("t4_ovf_held", 32'(io_data_in[5]), 32'd1);
        set_idle();
        cpu_wr(ST_A, 32'h20);
        peek("t4_stat_clr", ST_A);
        set_idle();
        repeat (8) cpu_pop();
        peek("t4_stat_drained", ST_A);
        set_idle();

        // unmapped and near-miss addresses
        cpu_wr(16'h3000, 32'hFF);
        cpu_wr(16'h1001, 32'h77);
        peek("unmapped_rd", 16'h3000);
        peek("nearmiss_rd", 16'h1001);
        peek("unmapped_stat", ST_A);
        set_idle();

        // 5: tick wrap and load
        cpu_wr(TK_A, 32'hFFFF_FFFE);
        peek("t5_tick_a", TK_A);
        check_val("t5_tick_a_const", io_data_in, 32'hFFFF_FFFF);
        set_idle();
        cycle();
        peek("t5_tick_b", TK_A);
        check_val("t5_tick_b_const", io_data_in, 32'h0);
        set_idle();
        cpu_wr(TK_A, $urandom);
        repeat (3) cycle();
        peek("t5_tick_rand", TK_A);
        set_idle();

        // random mixed traffic
        for (int n = 0; n < 80; n++) begin
            int op;
            op = $urandom_range(0, 4);
            tx_ready = 1'($urandom_range(0, 1));
            case (op)
                1: begin io_addr = TX_A; io_write_enable = 1'b1; io_wdata = $urandom; end
                2: begin rx_valid = 1'b1; rx_data = 8'($urandom); end
                3: begin io_addr = TX_A; io_read_enable = 1'b1; end
                4: begin io_addr = TX_A; io_read_enable = 1'b1;
                         rx_valid = 1'b1; rx_data = 8'($urandom); end
                default: ;
            endcase
            cycle();
            if (n % 10 == 9) begin
                peek("rand_stat", ST_A);
                set_idle();
            end
        end
        tx_ready = 1'b0;
        cpu_wr(ST_A, 32'h30);

        // 6: async reset with both FIFOs part full
        for (int i = 0; i < 4; i++) cpu_wr(TX_A, 32'(8'h60 + i));
        for (int i = 0; i < 4; i++) rx_send(8'(8'h70 + i));
        #1;
        resetq = 1'b0;
        #1;
        check_val("t6_tx_valid", 32'(tx_valid), 32'd0);
        check_val("t6_tx_data", 32'(tx_data), 32'd0);
        check_val("t6_rx_ready", 32'(rx_ready), 32'd1);
        io_addr = ST_A;
        #1;
        check_val("t6_stat", io_data_in, 32'h2);
        set_idle();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        resetq = 1'b1;
        cpu_wr(TX_A, 32'hE7);
        tx_ready = 1'b1;
        cycle();
        tx_ready = 1'b0;
        peek("t6_stat_after", ST_A);
        peek("t6_tick_after", TK_A);
        set_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
